// File: rtl/kmeans_centroid_update_k3_d5.sv
// K-means centroid update for 3 centroids x 5 dimensions: per-epoch accumulation, then sequential division.
// Define KMEANS_UPD_COUNT_OUT_EN to expose the per-centroid sample counts of the last epoch.
module kmeans_centroid_update_k3_d5 #(
  parameter int input_data_width  = 16,
  parameter int centroid_id_width = 2,
  parameter int count_width       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic [input_data_width-1:0]  input_data0,
  input  logic [input_data_width-1:0]  input_data1,
  input  logic [input_data_width-1:0]  input_data2,
  input  logic [input_data_width-1:0]  input_data3,
  input  logic [input_data_width-1:0]  input_data4,
  input  logic [centroid_id_width-1:0] selected_centroid,
  input  logic                         load_en,
  input  logic [centroid_id_width-1:0] load_id,
  input  logic [input_data_width-1:0]  load_data0,
  input  logic [input_data_width-1:0]  load_data1,
  input  logic [input_data_width-1:0]  load_data2,
  input  logic [input_data_width-1:0]  load_data3,
  input  logic [input_data_width-1:0]  load_data4,
  output logic [input_data_width-1:0]  centroid0_d0,
  output logic [input_data_width-1:0]  centroid0_d1,
  output logic [input_data_width-1:0]  centroid0_d2,
  output logic [input_data_width-1:0]  centroid0_d3,
  output logic [input_data_width-1:0]  centroid0_d4,
  output logic [input_data_width-1:0]  centroid1_d0,
  output logic [input_data_width-1:0]  centroid1_d1,
  output logic [input_data_width-1:0]  centroid1_d2,
  output logic [input_data_width-1:0]  centroid1_d3,
  output logic [input_data_width-1:0]  centroid1_d4,
  output logic [input_data_width-1:0]  centroid2_d0,
  output logic [input_data_width-1:0]  centroid2_d1,
  output logic [input_data_width-1:0]  centroid2_d2,
  output logic [input_data_width-1:0]  centroid2_d3,
  output logic [input_data_width-1:0]  centroid2_d4,
  output logic                         busy,
  output logic                         update_done
`ifdef KMEANS_UPD_COUNT_OUT_EN
  ,
  output logic [count_width-1:0]       count0,
  output logic [count_width-1:0]       count1,
  output logic [count_width-1:0]       count2
`endif
);

  localparam int sum_width  = input_data_width + count_width;
  localparam int step_width = $clog2(sum_width + 1);
  localparam int num_k      = 3;
  localparam int num_d      = 5;

  typedef enum logic [1:0] {ACC = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;

  state_t                        state;
  logic [input_data_width-1:0]   in_vec   [num_d];
  logic [input_data_width-1:0]   load_vec [num_d];
  logic [input_data_width-1:0]   cent     [num_k][num_d];
  logic [sum_width-1:0]          sums     [num_k][num_d];
  logic [count_width-1:0]        cnt      [num_k];
  logic [num_k-1:0]              sample_hit;
  logic [num_k-1:0]              load_hit;
  logic                          go_div;

  logic [sum_width-1:0]          div_q;
  logic [sum_width-1:0]          q_next;
  logic [count_width-1:0]        div_r;
  logic [count_width-1:0]        div_den;
  logic [count_width-1:0]        r_next;
  logic [count_width:0]          r_shift;
  logic [count_width:0]          r_sub;
  logic                          q_bit;
  logic [step_width-1:0]         div_step;
  logic [1:0]                    div_k;
  logic [2:0]                    div_d;
  logic                          step_last;
  logic                          div_last;
  logic                          wb_en;

  assign in_vec[0]   = input_data0;
  assign in_vec[1]   = input_data1;
  assign in_vec[2]   = input_data2;
  assign in_vec[3]   = input_data3;
  assign in_vec[4]   = input_data4;
  assign load_vec[0] = load_data0;
  assign load_vec[1] = load_data1;
  assign load_vec[2] = load_data2;
  assign load_vec[3] = load_data3;
  assign load_vec[4] = load_data4;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sample_hit = '0;
    load_hit   = '0;
    for (int k = 0; k < num_k; k++) begin
      sample_hit[k] = (state == ACC) && in_valid &&
                      (selected_centroid == centroid_id_width'(k)) && (cnt[k] != '1);
      load_hit[k]   = (state == ACC) && load_en && (load_id == centroid_id_width'(k));
    end
  end

  assign go_div = (state == ACC) && in_valid && in_last;

  // Restoring step: remainder stays below the divisor, so the borrow bit of r_sub decides the quotient bit.
  always_comb begin
    r_shift = {div_r, div_q[sum_width-1]};
    r_sub   = r_shift - {1'b0, div_den};
    q_bit   = ~r_sub[count_width];
    r_next  = q_bit ? r_sub[count_width-1:0] : r_shift[count_width-1:0];
    q_next  = {div_q[sum_width-2:0], q_bit};
  end

  assign step_last = (div_step == step_width'(sum_width));
  assign div_last  = (div_k == 2'd2) && (div_d == 3'd4);
  assign wb_en     = (state == DIV) && step_last && (div_den != '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACC;
      busy        <= 1'b0;
      update_done <= 1'b0;
      div_q       <= '0;
      div_r       <= '0;
      div_den     <= '0;
      div_step    <= '0;
      div_k       <= '0;
      div_d       <= '0;
    end else begin
      case (state)
        ACC: begin
          if (go_div) begin
            state    <= DIV;
            busy     <= 1'b1;
            div_step <= '0;
            div_k    <= '0;
            div_d    <= '0;
          end
        end
        DIV: begin
          if (div_step == '0) begin
            div_q    <= sums[div_k][div_d];
            div_r    <= '0;
            div_den  <= cnt[div_k];
            div_step <= step_width'(1);
          end else begin
            div_q <= q_next;
            div_r <= r_next;
            if (step_last) begin
              div_step <= '0;
              if (div_last) begin
                state       <= DONE;
                busy        <= 1'b0;
                update_done <= 1'b1;
              end else if (div_d == 3'd4) begin
                div_d <= '0;
                div_k <= div_k + 2'd1;
              end else begin
                div_d <= div_d + 3'd1;
              end
            end else begin
              div_step <= div_step + step_width'(1);
            end
          end
        end
        DONE: begin
          state       <= ACC;
          update_done <= 1'b0;
        end
        default: state <= ACC;
      endcase
    end
  end

  // NOTE: the accumulator arrays are reset because an aborted epoch must never leak into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < num_k; k++) begin
        cnt[k] <= '0;
        for (int d = 0; d < num_d; d++) sums[k][d] <= '0;
      end
    end else if (state == DONE) begin
      for (int k = 0; k < num_k; k++) begin
        cnt[k] <= '0;
        for (int d = 0; d < num_d; d++) sums[k][d] <= '0;
      end
    end else begin
      for (int k = 0; k < num_k; k++) begin
        if (sample_hit[k]) begin
          cnt[k] <= cnt[k] + count_width'(1);
          for (int d = 0; d < num_d; d++)
            sums[k][d] <= sums[k][d] + {{count_width{1'b0}}, in_vec[d]};
        end
      end
    end
  end

  // Loads happen only in ACC and writeback only in DIV, so the two never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < num_k; k++)
        for (int d = 0; d < num_d; d++) cent[k][d] <= '0;
    end else begin
      for (int k = 0; k < num_k; k++)
        if (load_hit[k])
          for (int d = 0; d < num_d; d++) cent[k][d] <= load_vec[d];
      if (wb_en) cent[div_k][div_d] <= q_next[input_data_width-1:0];
    end
  end

`ifdef KMEANS_UPD_COUNT_OUT_EN
  logic [count_width-1:0] count_nx [num_k];

  always_comb begin
    for (int k = 0; k < num_k; k++) count_nx[k] = cnt[k] + count_width'(sample_hit[k]);
  end

  // Captured on the closing edge so the final sample of the epoch is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count0 <= '0;
      count1 <= '0;
      count2 <= '0;
    end else if (go_div) begin
      count0 <= count_nx[0];
      count1 <= count_nx[1];
      count2 <= count_nx[2];
    end
  end
`endif

  assign centroid0_d0 = cent[0][0];
  assign centroid0_d1 = cent[0][1];
  assign centroid0_d2 = cent[0][2];
  assign centroid0_d3 = cent[0][3];
  assign centroid0_d4 = cent[0][4];
  assign centroid1_d0 = cent[1][0];
  assign centroid1_d1 = cent[1][1];
  assign centroid1_d2 = cent[1][2];
  assign centroid1_d3 = cent[1][3];
  assign centroid1_d4 = cent[1][4];
  assign centroid2_d0 = cent[2][0];
  assign centroid2_d1 = cent[2][1];
  assign centroid2_d2 = cent[2][2];
  assign centroid2_d3 = cent[2][3];
  assign centroid2_d4 = cent[2][4];

endmodule

// File: tb/tb_kmeans_centroid_update_k3_d5.sv
// Scoreboard bench for kmeans_centroid_update_k3_d5: stimulus pushes hand-computed centroid sets,
// a negedge monitor pops and compares them on every update_done pulse.
module tb_kmeans_centroid_update_k3_d5;

  localparam int W = 16;
  localparam int C = 16;
  localparam int DIV_CYCLES = 495;

  typedef logic [4:0][W-1:0] vec_t;

  typedef struct packed {
    logic [14:0][W-1:0] c;
    logic [2:0][C-1:0]  cnt;
    logic [31:0]        due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  vec_t       in_data = '0;
  logic [1:0] selected_centroid = '0;
  logic       load_en = 1'b0;
  logic [1:0] load_id = '0;
  vec_t       load_data = '0;
  wire [14:0][W-1:0] dut_c;
  wire [2:0][C-1:0]  dut_cnt;
  wire               busy;
  wire               update_done;

  exp_t               sb_q[$];
  logic [14:0][W-1:0] m_cent = '0;
  logic [2:0][C-1:0]  m_cnt = '0;
  int                 cyc = 0;
  int                 n_checks = 0;
  int                 n_pass = 0;

  kmeans_centroid_update_k3_d5 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .input_data0(in_data[0]), .input_data1(in_data[1]), .input_data2(in_data[2]),
    .input_data3(in_data[3]), .input_data4(in_data[4]),
    .selected_centroid(selected_centroid),
    .load_en(load_en), .load_id(load_id),
    .load_data0(load_data[0]), .load_data1(load_data[1]), .load_data2(load_data[2]),
    .load_data3(load_data[3]), .load_data4(load_data[4]),
    .centroid0_d0(dut_c[0]),  .centroid0_d1(dut_c[1]),  .centroid0_d2(dut_c[2]),
    .centroid0_d3(dut_c[3]),  .centroid0_d4(dut_c[4]),
    .centroid1_d0(dut_c[5]),  .centroid1_d1(dut_c[6]),  .centroid1_d2(dut_c[7]),
    .centroid1_d3(dut_c[8]),  .centroid1_d4(dut_c[9]),
    .centroid2_d0(dut_c[10]), .centroid2_d1(dut_c[11]), .centroid2_d2(dut_c[12]),
    .centroid2_d3(dut_c[13]), .centroid2_d4(dut_c[14]),
    .busy(busy), .update_done(update_done)
`ifdef KMEANS_UPD_COUNT_OUT_EN
    , .count0(dut_cnt[0]), .count1(dut_cnt[1]), .count2(dut_cnt[2])
`endif
  );

`ifndef KMEANS_UPD_COUNT_OUT_EN
  assign dut_cnt = '0;
`endif

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d, input int e);
    vec_t v;
    v[0] = W'(a); v[1] = W'(b); v[2] = W'(c); v[3] = W'(d); v[4] = W'(e);
    return v;
  endfunction

  function automatic vec_t rep(input int a);
    return mk(a, a, a, a, a);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input vec_t v, input bit last);
    in_valid = 1'b1;
    selected_centroid = 2'(k);
    in_data = v;
    in_last = last;
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic load(input int k, input vec_t v);
    load_en = 1'b1;
    load_id = 2'(k);
    load_data = v;
    step();
    load_en = 1'b0;
    if (k < 3) m_cent[k*5 +: 5] = v;
  endtask

  // Called right after the edge that accepted in_last; cyc already holds that edge's count.
  task automatic push_exp();
    exp_t e;
    e.c = m_cent;
    e.cnt = m_cnt;
    e.due = 32'(cyc + DIV_CYCLES);
    sb_q.push_back(e);
  endtask

  task automatic wait_drain();
    int i = 0;
    while (sb_q.size() != 0 && i < 700) begin
      @(negedge clk);
      i++;
    end
    check("drain_timeout", sb_q.size(), 0);
    sb_q.delete();
    step();
    step();
  endtask

  initial begin : monitor
    int   busy_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) busy_cnt = 0;
      else begin
        if (busy) busy_cnt++;
        if (update_done) begin
          check("done_expected", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("done_latency", cyc, e.due);
            check("busy_cycles", busy_cnt, DIV_CYCLES);
            for (int k = 0; k < 3; k++)
              check($sformatf("centroid%0d", k), dut_c[k*5 +: 5], e.c[k*5 +: 5]);
`ifdef KMEANS_UPD_COUNT_OUT_EN
            check("count_out", dut_cnt, e.cnt);
`endif
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin : stimulus
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_centroids", dut_c, 0);
    check("rst_busy", busy, 0);
    check("rst_update_done", update_done, 0);
    check("rst_counts", dut_cnt, 0);
    rst = 1'b0;
    step();

    // Epoch 1: k0 gets two samples, c1/c2 loaded and untouched, an id-3 sample is dropped.
    load(0, rep(10));
    load(1, rep(7));
    load_en = 1'b1; load_id = 2'd2; load_data = rep(5);
    in_valid = 1'b1; selected_centroid = 2'd0; in_data = mk(2, 4, 6, 8, 10);
    step();
    load_en = 1'b0; in_valid = 1'b0;
    m_cent[10 +: 5] = rep(5);
    send(3, rep(1000), 1'b0);
    m_cent[0 +: 5] = mk(3, 5, 7, 9, 11);
    m_cnt[0] = 16'd2; m_cnt[1] = 16'd0; m_cnt[2] = 16'd0;
    send(0, mk(4, 6, 8, 10, 13), 1'b1);
    push_exp();
    repeat (5) step();
    in_valid = 1'b1; in_last = 1'b1; selected_centroid = 2'd0; in_data = rep(1000);
    load_en = 1'b1; load_id = 2'd0; load_data = rep(999);
    step();
    in_valid = 1'b0; in_last = 1'b0; load_en = 1'b0;
    wait_drain();

    // Epoch 2: sums must not contain the sample pulsed during the division.
    send(1, mk(100, 200, 300, 400, 500), 1'b0);
    send(1, mk(101, 201, 301, 401, 502), 1'b0);
    send(0, mk(20, 21, 22, 23, 24), 1'b0);
    load(3, rep(4444));
    check("load_id3_ignored", dut_c, m_cent);
    m_cent[0 +: 5] = mk(20, 21, 22, 23, 24);
    m_cent[5 +: 5] = mk(101, 201, 301, 401, 501);
    m_cnt[0] = 16'd1; m_cnt[1] = 16'd3; m_cnt[2] = 16'd0;
    send(1, mk(102, 202, 302, 402, 503), 1'b1);
    push_exp();
    wait_drain();

    // Epoch 3: the closing sample targets id 3 and is dropped, but still ends the epoch.
    send(2, rep(9), 1'b0);
    send(2, rep(11), 1'b0);
    m_cent[10 +: 5] = rep(10);
    m_cnt[0] = 16'd0; m_cnt[1] = 16'd0; m_cnt[2] = 16'd2;
    send(3, rep(60000), 1'b1);
    push_exp();
    wait_drain();

    // Two back-to-back full-scale epochs on k2.
    for (int ep = 0; ep < 2; ep++) begin
      send(2, rep(65535), 1'b0);
      send(2, rep(65535), 1'b0);
      m_cent[10 +: 5] = rep(65535);
      m_cnt[0] = 16'd0; m_cnt[1] = 16'd0; m_cnt[2] = 16'd3;
      send(2, rep(65535), 1'b1);
      push_exp();
      wait_drain();
    end

    // Reset 100 cycles into the division: no pulse, everything cleared.
    send(0, mk(50, 52, 54, 56, 58), 1'b1);
    repeat (100) step();
    check("busy_mid_div", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_centroids", dut_c, 0);
    check("abort_busy", busy, 0);
    check("abort_update_done", update_done, 0);
    check("abort_counts", dut_cnt, 0);
    m_cent = '0;
    m_cnt = '0;
    step();
    rst = 1'b0;
    step();

    // Next epoch must start from zero sums.
    m_cent[0 +: 5] = mk(6, 7, 8, 9, 10);
    m_cnt[0] = 16'd1;
    send(0, mk(6, 7, 8, 9, 10), 1'b1);
    push_exp();
    wait_drain();

    repeat (10) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kmeans_centroid_update_k3_d5.md
KMEANS_CENTROID_UPDATE_K3_D5 -- requirements
Module: kmeans_centroid_update_k3_d5

Interface
REQ-001 Parameter input_data_width, default 16, SHALL set the width of each sample dimension and each centroid coordinate.
REQ-002 Parameter centroid_id_width, default 2, SHALL set the width of the centroid id.
REQ-003 Parameter count_width, default 16, SHALL set the width of each per-centroid sample counter; sum width SHALL be input_data_width+count_width.
REQ-004 Port clk, input, 1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1: a classified sample is present this cycle.
REQ-007 Port in_last, input, 1: qualified by in_valid; marks the final sample of an epoch.
REQ-008 Ports input_data0..input_data4, input, input_data_width each: sample dimensions d0..d4, unsigned.
REQ-009 Port selected_centroid, input, centroid_id_width: winning centroid id for the sample.
REQ-010 Port load_en, input, 1: writes initial centroid coordinates.
REQ-011 Port load_id, input, centroid_id_width: centroid index written by load_en.
REQ-012 Ports load_data0..load_data4, input, input_data_width each: coordinates written by load_en.
REQ-013 Ports centroid0_d0..centroid2_d4 (15 ports), output reg, input_data_width each: current centroid coordinates.
REQ-014 Port busy, output reg, 1: high while in state DIV.
REQ-015 Port update_done, output reg, 1: single-cycle pulse when new centroids are valid.

Function
REQ-016 The FSM SHALL have states ACC, DIV, and DONE; the reset state SHALL be ACC.
REQ-017 In ACC, each cycle with in_valid=1 and selected_centroid in 0..2 SHALL add input_data0..4 to sum[k][0..4] and increment count[k], where k=selected_centroid.
REQ-018 A sample with selected_centroid=3 SHALL be discarded; it SHALL change no sums or counts, but in_last on it SHALL still be honoured.
REQ-019 When count[k] equals 2^count_width-1, further samples for k SHALL be discarded, with sums and the counter unchanged (saturation).
REQ-020 An accepted sample with in_last=1 SHALL be accumulated first; the state SHALL be DIV in the next cycle.
REQ-021 In DIV, a sequential restoring divider SHALL compute sum[k][d]/count[k] (unsigned, truncated), one quotient bit per cycle.
REQ-022 The divider SHALL take sum_width+1 cycles per division (1 load cycle, then sum_width iterate cycles).
REQ-023 The divider SHALL process the 15 divisions in the order k0d0..k0d4, k1d0..k2d4.
REQ-024 Each quotient's low input_data_width bits SHALL be written to the matching centroid output in the division's final cycle.
REQ-025 If count[k]=0, the division cycles for k SHALL still elapse, but the centroid k outputs SHALL keep their prior values.
REQ-026 After the 15th division the state SHALL be DONE for exactly one cycle, with update_done=1.
REQ-027 DONE SHALL clear all sums and counts and return to ACC.
REQ-028 Latency from the in_last acceptance edge to the update_done=1 cycle SHALL be 15*(sum_width+1)+1 cycles (496 at default parameters).
REQ-029 in_valid and load_en SHALL be ignored in DIV and DONE.
REQ-030 In ACC, load_en=1 with load_id in 0..2 SHALL write load_data0..4 to centroid[load_id] on that edge; load_id=3 SHALL be ignored.
REQ-031 A simultaneous load_en and in_valid in ACC SHALL both take effect.
REQ-032 Centroid outputs SHALL change only by load or by division writeback.

Reset
REQ-033 On rst, state SHALL go to ACC, and all sums, counts, and divider registers SHALL clear to 0.
REQ-034 On rst, all centroid outputs SHALL clear to 0, busy=0, and update_done=0.
REQ-035 A reset asserted mid-DIV SHALL abort the update without producing an update_done pulse.

Configuration
REQ-036 With macro KMEANS_UPD_COUNT_OUT_EN defined, output ports count0..count2 (count_width each) SHALL be present.
REQ-037 Each countN SHALL be captured in the ACC->DIV transition and SHALL hold until the next such transition or reset (reset value 0).
REQ-038 Without KMEANS_UPD_COUNT_OUT_EN, ports count0..count2 and their registers SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-039 Scenario: load c0=(10,10,10,10,10); feed samples to k0: (2,4,6,8,10) then (4,6,8,10,13) with in_last -> 496 cycles later, update_done pulses and c0=(3,5,7,9,11).
REQ-040 Scenario: load c1=(7,7,7,7,7); epoch with no samples to k1 -> c1 stays (7,7,7,7,7), and update_done still occurs on schedule.
REQ-041 Scenario: the sample with in_last has selected_centroid=3 -> it is dropped, DIV starts the next cycle, and busy=1 for exactly 495 cycles.
REQ-042 Scenario: assert rst at cycle 100 of DIV -> all outputs are 0 immediately, no update_done pulse, and the next epoch accumulates from zero sums.
REQ-043 Scenario: two back-to-back epochs, each with 3 samples to k2 of value 65535 -> c2=65535 after both epochs, with no overflow; with the macro, count2=3.
REQ-044 Scenario: in_valid pulsed during DIV with value 1000 -> the result is unaffected, and the next epoch's sums exclude it.
